// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, data width and bit-period helper.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // clk cycles per bit; integer division matches the transmit path's rounding
  function automatic int bps_para(input int clk_mhz, input int baud);
    return (clk_mhz * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Restartable bit-period counter with mid-bit and end-of-bit ticks.
module uart_bit_timer #(
  parameter int BPS_PARA = 5208,
  parameter int BPS_HALF = 2604,
  parameter int CW       = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic half_tick,
  output logic full_tick
);

  logic [CW-1:0] cnt;

  assign half_tick = (cnt == CW'(BPS_HALF - 1));
  assign full_tick = (cnt == CW'(BPS_PARA - 1));

  // Wrap on full_tick as a safety net so the count never passes BPS_PARA-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !run || full_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: start-edge restarted bit timer, mid-bit sampling,
// one-cycle rx_valid / frame_err strobes.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 9600
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int BPS_PARA = bps_para(CLK_FRE, BAUD_RATE);
  localparam int BPS_HALF = BPS_PARA / 2;
  localparam int CW       = $clog2(BPS_PARA + 1);

  logic                      s1, s2, s3;
  logic                      fall;
  logic                      half_tick, full_tick;
  logic                      timer_clear, timer_run;
  uart_rx_state_t            state;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;

  // Counter is held at zero in IDLE and restarted at every sample point
  assign timer_run   = (state != IDLE);
  assign timer_clear = (state == IDLE)
                    || ((state == START) && half_tick)
                    || (((state == DATA) || (state == STOP)) && full_tick);

  uart_bit_timer #(
    .BPS_PARA (BPS_PARA),
    .BPS_HALF (BPS_HALF),
    .CW       (CW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (timer_clear),
    .run       (timer_run),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (half_tick) begin
            if (s2) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (full_tick) begin
            shreg   <= {s2, shreg[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (full_tick) begin
            if (s2) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx at a scaled-down rate (100 clk per bit) so every
// frame-level scenario fits in a short run; timing is checked to the cycle.
module tb_uart_byte_rx;

  localparam int CLK_FRE   = 1;
  localparam int BAUD_RATE = 10000;
  localparam int PARA      = 100;
  localparam int HALF      = 50;
  localparam int EV_DELAY  = 2 + HALF + 9 * PARA;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_byte_rx #(
    .CLK_FRE   (CLK_FRE),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         cyc;
    int         kind;   // 1 = valid, 2 = frame error, 3 = both
    logic [7:0] data;
  } ev_t;

  ev_t  evq[$];
  int   busy_falls[$];
  logic busy_q = 1'b0;
  ev_t  mon_e;

  always @(negedge clk) begin
    if (rx_valid || frame_err) begin
      mon_e.cyc  = cyc;
      mon_e.kind = (rx_valid ? 1 : 0) + (frame_err ? 2 : 0);
      mon_e.data = rx_data;
      evq.push_back(mon_e);
    end
    if (busy_q && !busy) busy_falls.push_back(cyc);
    busy_q = busy;
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stopb, input int per, output int e0);
    e0  = cyc + 1;
    rxd = 1'b0;
    idle(per);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(per);
    end
    rxd = stopb;
    idle(per);
    rxd = 1'b1;
  endtask

  // Reference: each accepted frame yields one event at E0+EV_DELAY; a good stop
  // bit delivers the byte, a bad one reports an error with rx_data unchanged.
  task automatic expect_event(input string tag, input int e0, input int kind, input logic [7:0] data);
    ev_t e;
    chk({tag, "_present"}, (evq.size() > 0), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk({tag, "_kind"}, e.kind, kind);
      chk({tag, "_cycle"}, e.cyc, e0 + EV_DELAY);
      chk({tag, "_data"}, e.data, data);
    end
  endtask

  initial begin
    int         e0, ea, eb, gap;
    logic [7:0] prev, b;
    logic       stopb;

    rst_n = 1'b0;
    rxd   = 1'b1;
    idle(5);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(20);

    busy_falls.delete();
    send(8'h55, 1'b1, PARA, e0);
    expect_event("f55", e0, 1, 8'h55);
    chk("f55_busy_fall", (busy_falls.size() > 0) ? busy_falls[0] : -1, e0 + EV_DELAY);
    chk("f55_single_pulse", evq.size(), 0);

    send(8'hA3, 1'b1, PARA, ea);
    send(8'h3C, 1'b1, PARA, eb);
    expect_event("b2b_a3", ea, 1, 8'hA3);
    expect_event("b2b_3c", eb, 1, 8'h3C);
    chk("b2b_rx_data", rx_data, 8'h3C);
    idle(PARA);

    busy_falls.delete();
    e0  = cyc + 1;
    rxd = 1'b0;
    idle(20);
    rxd = 1'b1;
    idle(10);
    chk("glitch_busy_high", busy, 1);
    idle(3 * PARA);
    chk("glitch_busy_low", busy, 0);
    chk("glitch_busy_fall", (busy_falls.size() > 0) ? busy_falls[0] : -1, e0 + 2 + HALF);
    chk("glitch_no_event", evq.size(), 0);
    send(8'h81, 1'b1, PARA, e0);
    expect_event("f81", e0, 1, 8'h81);

    send(8'h7E, 1'b0, PARA, e0);
    expect_event("f7e_ferr", e0, 2, 8'h81);
    chk("f7e_rx_data_held", rx_data, 8'h81);
    idle(PARA);
    send(8'h00, 1'b1, PARA, e0);
    expect_event("f00", e0, 1, 8'h00);

    send(8'hC9, 1'b1, 98, e0);
    expect_event("fast_c9", e0, 1, 8'hC9);
    send(8'hC9, 1'b1, 102, e0);
    expect_event("slow_c9", e0, 1, 8'hC9);
    idle(PARA);

    rxd = 1'b0;
    idle(5 * PARA);
    rxd = 1'b1;
    idle(PARA / 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rx_data", rx_data, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(12 * PARA);
    chk("midrst_no_event", evq.size(), 0);
    send(8'h5A, 1'b1, PARA, e0);
    expect_event("f5a", e0, 1, 8'h5A);

    prev = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      b     = 8'($urandom);
      stopb = ($urandom_range(3) != 0);
      send(b, stopb, PARA, e0);
      if (stopb) begin
        expect_event($sformatf("rnd%0d", k), e0, 1, b);
        prev = b;
        gap  = $urandom_range(2);
      end else begin
        expect_event($sformatf("rnd%0d", k), e0, 2, prev);
        gap  = $urandom_range(2, 1);
      end
      idle(gap * PARA);
    end
    chk("rnd_rx_data", rx_data, prev);
    idle(2 * PARA);
    chk("final_no_extra_event", evq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
